dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory slave at the far end of the core's MEM-stage data port.
- Accepts one load or store request per transaction, with the access size encoded as mem_access_size_t.
- Inserts a programmable number of wait states, then commits the store or returns the load data, with a one-cycle response pulse.
- Load data is right-aligned and zero-extended; sign extension stays in the core's WB stage.

Parameters:
- DEPTH, 1024, number of 32-bit words in the backing array; must be a power of two.
- WAIT_CYCLES, 2, wait states between acceptance and response (0..15).

Ports:
- clk_i  input  1  clock
- reset_ni  input  1  asynchronous active-low reset
- req_valid_i  input  1  request present; sampled only when busy_o=0
- req_addr_i  input  32  byte address
- req_we_i  input  1  1=store, 0=load
- req_size_i  input  2  mem_access_size_t (BYTE/HALF/WORD)
- req_wdata_i  input  32  store data, right-aligned
- busy_o  output  1  transaction in flight; the core must hold its MEM stage while high
- resp_valid_o  output  1  one-cycle pulse; transaction complete
- resp_rdata_o  output  32  load result, zero-extended; 0 for stores and errors
- resp_err_o  output  1  misaligned or out-of-range; valid with resp_valid_o

Behaviour:
- Reset (async assert, sync deassert in the core's reset domain):
  - state=IDLE; busy_o=0, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0.
  - Array contents are not cleared.
- Reset mid-transaction:
  - Return to IDLE; the pending store is dropped and no response is issued.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on req_valid_i, latch addr/we/size/wdata and load wait counter=WAIT_CYCLES-1. Go to WAIT if WAIT_CYCLES>0, else to RESP.
  - WAIT: decrement the counter; go to RESP when the counter is 0.
  - RESP: resp_valid_o=1 for exactly this cycle, then return to IDLE.
  - No request is accepted in RESP.
- busy_o = (state != IDLE), registered.
- Latency: resp_valid_o rises WAIT_CYCLES+1 cycles after the accepting edge. Minimum issue interval is WAIT_CYCLES+2 cycles.
- Inputs are ignored while busy_o=1; changing them has no effect on the latched request.
- Error check, decided at acceptance from the latched fields:
  - HALF with addr[0]=1.
  - WORD with addr[1:0]!=0.
  - addr[31:2] >= DEPTH.
  - Reserved size encoding.
- Error response: resp_err_o=1, resp_rdata_o=0, and no array write.
- Word index = addr[$clog2(DEPTH)+1:2].
- Store, committed on the RESP clock edge:
  - BYTE: lane addr[1:0] gets wdata[7:0].
  - HALF: lanes {addr[1],0} and {addr[1],1} get wdata[15:0].
  - WORD: all four lanes.
  - Other lanes are preserved.
- Load: the array word is read in the last WAIT/IDLE→RESP transition and presented in RESP.
  - BYTE: (word >> 8*addr[1:0]) & 0xFF.
  - HALF: (word >> 16*addr[1]) & 0xFFFF.
  - WORD: the whole word.
- Outside RESP, resp_rdata_o and resp_err_o are 0.

Decomposition:
- definitions package:
  - reuse mem_access_size_t;
  - add dmem_resp_state_t (IDLE/WAIT/RESP);
  - add constant DMEM_WAIT_W=4.
- One sub-module, dmem_lane_align (combinational): from size and addr[1:0], produces
  - the 4-bit byte enable,
  - the replicated write data,
  - the read extract/zero-extend,
  - the misalign flag.

Test Plan:
- Reset asserted while in WAIT after a SW to 0x10 → busy_o=0 immediately and no resp_valid_o. A subsequent LW 0x10 returns the prior contents.
- WAIT_CYCLES=2, SW 0x100 data 0xDEADBEEF → busy_o high 3 cycles, resp_valid_o pulse in cycle 3, err=0. Then LW 0x100 → rdata=0xDEADBEEF.
- After the word above, SB 0x102 data 0x55, then LW 0x100 → 0xDE55BEEF. LBU 0x103 → 0x000000DE. LH 0x102 → 0x0000DE55.
- LW 0x102 → resp_err_o=1, rdata=0. SH 0x101 → err=1, and LW 0x100 is unchanged.
- DEPTH=1024, LW 0x1000 → err=1. LW 0xFFC → no error.
- WAIT_CYCLES=0 with req_valid_i held high continuously → responses every 2 cycles. Inputs toggled while busy are not captured.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared types and constants for the data-memory responder.
// Revision 1.0
`default_nettype none

package dmem_responder_pkg;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'd0,
    MEM_SIZE_HALF = 2'd1,
    MEM_SIZE_WORD = 2'd2
  } mem_access_size_t;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_resp_state_t;

  localparam int DMEM_WAIT_W = 4;

endpackage

`default_nettype wire

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM-stage data port between the core (master) and the responder (slave).
// Revision 1.0
`default_nettype none

interface dmem_responder_if;

  logic        req_valid_i;
  logic [31:0] req_addr_i;
  logic        req_we_i;
  // Kept as raw bits so the reserved size encoding can reach the error check.
  logic [1:0]  req_size_i;
  logic [31:0] req_wdata_i;
  logic        busy_o;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;

  modport master (
    output req_valid_i, req_addr_i, req_we_i, req_size_i, req_wdata_i,
    input  busy_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_we_i, req_size_i, req_wdata_i,
    output busy_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

endinterface

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte enables, write-data replication, load extraction and alignment check.
// Revision 1.0
`default_nettype none

module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata_rep,
  output logic [31:0] o_rdata,
  output logic        o_misalign,
  output logic        o_size_bad
);

  logic [31:0] w_byte_sh;
  logic [31:0] w_half_sh;

  assign w_byte_sh = i_rword >> {i_addr_lo, 3'b000};
  assign w_half_sh = i_rword >> {i_addr_lo[1], 4'b0000};

  always_comb begin
    o_be        = 4'b0000;
    o_wdata_rep = '0;
    o_rdata     = '0;
    o_misalign  = 1'b0;
    o_size_bad  = 1'b0;
    case (i_size)
      MEM_SIZE_BYTE: begin
        o_be        = 4'b0001 << i_addr_lo;
        o_wdata_rep = {4{i_wdata[7:0]}};
        o_rdata     = {24'h000000, w_byte_sh[7:0]};
      end
      MEM_SIZE_HALF: begin
        o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata_rep = {2{i_wdata[15:0]}};
        o_rdata     = {16'h0000, w_half_sh[15:0]};
        o_misalign  = i_addr_lo[0];
      end
      MEM_SIZE_WORD: begin
        o_be        = 4'b1111;
        o_wdata_rep = i_wdata;
        o_rdata     = i_rword;
        o_misalign  = |i_addr_lo;
      end
      default: begin
        o_size_bad  = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave with programmable wait states and a one-cycle response pulse.
// Revision 1.0
`default_nettype none

module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  dmem_responder_if.slave   bus
);

  localparam int c_IDX_W = $clog2(DEPTH);
  localparam logic [DMEM_WAIT_W-1:0] c_CNT_INIT =
    (WAIT_CYCLES > 0) ? DMEM_WAIT_W'(WAIT_CYCLES - 1) : '0;

  dmem_resp_state_t        r_state;
  dmem_resp_state_t        w_state_nxt;
  logic [DMEM_WAIT_W-1:0]  r_cnt;
  logic [DMEM_WAIT_W-1:0]  w_cnt_nxt;
  logic                    w_accept;

  logic [31:0]  r_addr;
  logic         r_we;
  logic [1:0]   r_size;
  logic [31:0]  r_wdata;
  logic         r_busy;
  logic         r_resp_valid;
  logic [31:0]  r_resp_rdata;
  logic         r_resp_err;
  logic [31:0]  r_mem [DEPTH];

  logic               w_idle;
  logic [31:0]        w_addr;
  logic               w_we;
  logic [1:0]         w_size;
  logic [31:0]        w_wdata;
  logic [c_IDX_W-1:0] w_idx;
  logic [31:0]        w_rword;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata_rep;
  logic [31:0]        w_rdata_ext;
  logic               w_misalign;
  logic               w_size_bad;
  logic               w_range_bad;
  logic               w_err;
  logic               w_commit;

  // In IDLE the live request is evaluated so a zero-wait access can respond next cycle.
  assign w_idle  = (r_state == DMEM_IDLE);
  assign w_addr  = w_idle ? bus.req_addr_i  : r_addr;
  assign w_we    = w_idle ? bus.req_we_i    : r_we;
  assign w_size  = w_idle ? bus.req_size_i  : r_size;
  assign w_wdata = w_idle ? bus.req_wdata_i : r_wdata;

  assign w_idx       = w_addr[c_IDX_W+1:2];
  assign w_rword     = r_mem[w_idx];
  assign w_range_bad = (w_addr[31:2] >= 30'(DEPTH));
  assign w_err       = w_misalign | w_size_bad | w_range_bad;
  assign w_commit    = (r_state == DMEM_RESP) && r_we && !w_err;

  dmem_lane_align u_lane_align (
    .i_size      (w_size),
    .i_addr_lo   (w_addr[1:0]),
    .i_wdata     (w_wdata),
    .i_rword     (w_rword),
    .o_be        (w_be),
    .o_wdata_rep (w_wdata_rep),
    .o_rdata     (w_rdata_ext),
    .o_misalign  (w_misalign),
    .o_size_bad  (w_size_bad)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      DMEM_IDLE: begin
        if (bus.req_valid_i) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = c_CNT_INIT;
          w_state_nxt = (WAIT_CYCLES > 0) ? DMEM_WAIT : DMEM_RESP;
        end
      end
      DMEM_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = DMEM_RESP;
        end else begin
          w_cnt_nxt   = r_cnt - 1'b1;
        end
      end
      DMEM_RESP: begin
        w_state_nxt = DMEM_IDLE;
      end
      default: begin
        w_state_nxt = DMEM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state      <= DMEM_IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_wdata      <= '0;
      r_busy       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      if (w_accept) begin
        r_addr  <= bus.req_addr_i;
        r_we    <= bus.req_we_i;
        r_size  <= bus.req_size_i;
        r_wdata <= bus.req_wdata_i;
      end
      r_busy       <= (w_state_nxt != DMEM_IDLE);
      r_resp_valid <= (w_state_nxt == DMEM_RESP);
      r_resp_err   <= (w_state_nxt == DMEM_RESP) && w_err;
      r_resp_rdata <= ((w_state_nxt == DMEM_RESP) && !w_err && !w_we) ? w_rdata_ext : '0;
    end
  end

  // Backing array is deliberately not reset; the commit is gated by the reset-cleared state.
  always_ff @(posedge clk_i) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
        end
      end
    end
  end

  assign bus.busy_o       = r_busy;
  assign bus.resp_valid_o = r_resp_valid;
  assign bus.resp_rdata_o = r_resp_rdata;
  assign bus.resp_err_o   = r_resp_err;

endmodule

`default_nettype wire
